// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central hazard / stall controller for the 5-stage RV32I pipeline.
//   Produces per-segment-register hold (bubble) and kill (flush) controls,
//   tracks data-memory miss stalls with a two-state FSM, watches miss length
//   with a sticky timeout flag and counts fetch-stall cycles.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rs1_D, rs2_D        source register indices of the ID instruction
//   rs1_used_D,
//   rs2_used_D          ID instruction actually reads rs1 / rs2
//   csr_read_D          ID instruction reads a CSR
//   jal_D               JAL resolved in ID
//   rd_E, load_E        EX destination register, EX instruction is a load
//   csr_write_en_E/_M   EX / MEM instruction writes a CSR
//   br_taken_E, jalr_E  EX redirect (taken branch / JALR)
//   miss_M              data-memory miss, held until served
//   mem_ready_M         miss data valid this cycle
//   bubble[4:0]         hold segment register (bit0=F .. bit4=W)
//   flush[4:0]          load NOP into segment register (same order)
//   miss_timeout        sticky watchdog flag, cleared only by rst
//   stall_cycles        saturating count of cycles with bubble[0]=1
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned MISS_TIMEOUT = 64,
  parameter int unsigned TO_W         = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic             csr_read_D,
  input  logic             jal_D,
  input  logic [4:0]       rd_E,
  input  logic             load_E,
  input  logic             csr_write_en_E,
  input  logic             br_taken_E,
  input  logic             jalr_E,
  input  logic             csr_write_en_M,
  input  logic             miss_M,
  input  logic             mem_ready_M,
  output logic [4:0]       bubble,
  output logic [4:0]       flush,
  output logic             miss_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_MISS = 1'b1;

  // Control patterns, bit order {W, M, E, D, F}
  localparam logic [4:0] MISS_BUBBLE  = 5'b01111;
  localparam logic [4:0] MISS_FLUSH   = 5'b10000;
  localparam logic [4:0] REDIR_FLUSH  = 5'b00110;
  localparam logic [4:0] HAZ_BUBBLE   = 5'b00011;
  localparam logic [4:0] HAZ_FLUSH    = 5'b00100;
  localparam logic [4:0] JAL_FLUSH    = 5'b00010;

  localparam logic [TO_W-1:0] TIMEOUT_CMP = TO_W'(MISS_TIMEOUT - 1);

  logic [0:0]       state_q,        state_d;
  logic [TO_W-1:0]  miss_cnt_q,     miss_cnt_d;
  logic             miss_timeout_q, miss_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  // Hazard detection
  logic stall_m;
  logic redirect_e;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic csr_hazard;

  always_comb begin
    stall_m    = miss_M & ~mem_ready_M;
    redirect_e = br_taken_E | jalr_E;
    rs1_hit    = rs1_used_D & (rs1_D == rd_E);
    rs2_hit    = rs2_used_D & (rs2_D == rd_E);
    // x0 is hardwired zero, so a load targeting it never creates a dependency
    load_use   = load_E & (rd_E != 5'd0) & (rs1_hit | rs2_hit);
    csr_hazard = csr_read_D & (csr_write_en_E | csr_write_en_M);
  end

  // Segment controls: combinational, zero latency
  always_comb begin
    bubble = '0;
    flush  = '0;
    if (rst) begin
      flush = '1;
    end else begin
      case (state_q)
        ST_RUN: begin
          // A miss freezes EX, so a pending redirect re-presents afterwards;
          // a redirect kills the ID instruction, so ID hazards are moot.
          if (stall_m) begin
            bubble = MISS_BUBBLE;
            flush  = MISS_FLUSH;
          end else if (redirect_e) begin
            flush  = REDIR_FLUSH;
          end else if (load_use || csr_hazard) begin
            bubble = HAZ_BUBBLE;
            flush  = HAZ_FLUSH;
          end else if (jal_D) begin
            flush  = JAL_FLUSH;
          end
        end
        ST_MISS: begin
          if (!mem_ready_M) begin
            bubble = MISS_BUBBLE;
            flush  = MISS_FLUSH;
          end
        end
        default: begin
          bubble = '0;
          flush  = '0;
        end
      endcase
    end
  end

  // Miss FSM: miss with same-cycle ready in RUN is a plain hit
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (stall_m)     state_d = ST_MISS;
      ST_MISS: if (mem_ready_M) state_d = ST_RUN;
      default:                  state_d = ST_RUN;
    endcase
  end

  // Miss-duration counter and sticky watchdog
  always_comb begin
    miss_cnt_d     = miss_cnt_q;
    miss_timeout_d = miss_timeout_q;
    if (state_q == ST_RUN) begin
      if (stall_m) begin
        miss_cnt_d = '0;
      end
    end else begin
      if (miss_cnt_q != '1) begin
        miss_cnt_d = miss_cnt_q + TO_W'(1);
      end
      if (miss_cnt_q == TIMEOUT_CMP) begin
        miss_timeout_d = 1'b1;
      end
    end
  end

  // Saturating fetch-stall performance counter
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (bubble[0] && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      miss_cnt_q     <= '0;
      miss_timeout_q <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      miss_cnt_q     <= miss_cnt_d;
      miss_timeout_q <= miss_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign miss_timeout = miss_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Two instances share one stimulus stream: dut_a with default parameters and
//   dut_b with MISS_TIMEOUT=4, CNT_W=4. A cycle-level behavioural model checks
//   every output of both instances each cycle; directed scenarios add literal
//   expectations, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO_A = 64;
  localparam int unsigned TO_B = 4;
  localparam int unsigned MAX_A = 65535;
  localparam int unsigned MAX_B = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_D, rs2_D, rd_E;
  logic       rs1_used_D, rs2_used_D, csr_read_D, jal_D;
  logic       load_E, csr_write_en_E, br_taken_E, jalr_E;
  logic       csr_write_en_M, miss_M, mem_ready_M;

  logic [4:0]  bubble_a, flush_a, bubble_b, flush_b;
  logic        to_a, to_b;
  logic [15:0] sc_a;
  logic [3:0]  sc_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .csr_read_D(csr_read_D),
    .jal_D(jal_D), .rd_E(rd_E), .load_E(load_E), .csr_write_en_E(csr_write_en_E),
    .br_taken_E(br_taken_E), .jalr_E(jalr_E), .csr_write_en_M(csr_write_en_M),
    .miss_M(miss_M), .mem_ready_M(mem_ready_M), .bubble(bubble_a), .flush(flush_a),
    .miss_timeout(to_a), .stall_cycles(sc_a)
  );

  pipe_hazard_ctrl #(.MISS_TIMEOUT(TO_B), .TO_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .csr_read_D(csr_read_D),
    .jal_D(jal_D), .rd_E(rd_E), .load_E(load_E), .csr_write_en_E(csr_write_en_E),
    .br_taken_E(br_taken_E), .jalr_E(jalr_E), .csr_write_en_M(csr_write_en_M),
    .miss_M(miss_M), .mem_ready_M(mem_ready_M), .bubble(bubble_b), .flush(flush_b),
    .miss_timeout(to_b), .stall_cycles(sc_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_miss = 1'b0;   // waiting on a data-memory miss
  int unsigned m_len  = 0;      // MISS cycles elapsed in the current miss
  bit          m_to_a = 1'b0, m_to_b = 1'b0;
  int unsigned m_sc_a = 0, m_sc_b = 0;

  // Expected {bubble, flush} from the priority rules
  function automatic logic [9:0] exp_ctrl(input bit in_miss);
    bit dep;
    if (rst) return {5'b00000, 5'b11111};
    if (in_miss) return mem_ready_M ? 10'd0 : {5'b01111, 5'b10000};
    if (miss_M && !mem_ready_M) return {5'b01111, 5'b10000};
    if (br_taken_E || jalr_E) return {5'b00000, 5'b00110};
    dep = load_E && rd_E != 0 &&
          ((rs1_used_D && rs1_D == rd_E) || (rs2_used_D && rs2_D == rd_E));
    if (dep || (csr_read_D && (csr_write_en_E || csr_write_en_M)))
      return {5'b00011, 5'b00100};
    if (jal_D) return {5'b00000, 5'b00010};
    return 10'd0;
  endfunction

  always @(negedge clk) begin
    logic [9:0] e;
    e = exp_ctrl(m_miss);
    chk("bubble_a", 32'(bubble_a), 32'(e[9:5]));
    chk("flush_a",  32'(flush_a),  32'(e[4:0]));
    chk("bubble_b", 32'(bubble_b), 32'(e[9:5]));
    chk("flush_b",  32'(flush_b),  32'(e[4:0]));
    chk("timeout_a", 32'(to_a), 32'(m_to_a));
    chk("timeout_b", 32'(to_b), 32'(m_to_b));
    chk("stall_cycles_a", 32'(sc_a), m_sc_a);
    chk("stall_cycles_b", 32'(sc_b), m_sc_b);
    // advance the model to what the coming clock edge must produce
    if (rst) begin
      m_miss = 0; m_len = 0; m_to_a = 0; m_to_b = 0; m_sc_a = 0; m_sc_b = 0;
    end else begin
      if (e[5]) begin
        if (m_sc_a < MAX_A) m_sc_a++;
        if (m_sc_b < MAX_B) m_sc_b++;
      end
      if (m_miss) begin
        m_len++;
        if (m_len == TO_A) m_to_a = 1;
        if (m_len == TO_B) m_to_b = 1;
        if (mem_ready_M) m_miss = 0;
      end else if (miss_M && !mem_ready_M) begin
        m_miss = 1;
        m_len  = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_idle();
    rst = 0; rs1_D = 0; rs2_D = 0; rd_E = 0;
    rs1_used_D = 0; rs2_used_D = 0; csr_read_D = 0; jal_D = 0;
    load_E = 0; csr_write_en_E = 0; br_taken_E = 0; jalr_E = 0;
    csr_write_en_M = 0; miss_M = 0; mem_ready_M = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #2;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    next_cycle(); set_idle(); rst = 1; sample();
    next_cycle(); set_idle();
  endtask

  initial begin
    bit miss_act;
    int unsigned miss_left;

    // Reset with a miss pending
    set_idle(); rst = 1; miss_M = 1;
    sample();
    chk("rst_flush", 32'(flush_a), 32'h1f);
    chk("rst_bubble", 32'(bubble_a), 32'h0);
    chk("rst_stall_cycles", 32'(sc_a), 32'd0);
    next_cycle(); sample();
    chk("rst_flush2", 32'(flush_a), 32'h1f);
    next_cycle(); rst = 0; sample();
    chk("rel_bubble", 32'(bubble_a), 32'h0f);
    chk("rel_flush", 32'(flush_a), 32'h10);
    next_cycle(); sample();
    chk("miss_state_bubble", 32'(bubble_a), 32'h0f);
    chk("miss_state_sc", 32'(sc_a), 32'd1);
    next_cycle(); mem_ready_M = 1; sample();
    chk("ready_bubble", 32'(bubble_a), 32'h0);
    next_cycle(); set_idle(); sample();
    chk("after_ready_sc", 32'(sc_a), 32'd2);

    // Load-use on rs2, then the same with rd_E = x0
    do_reset();
    load_E = 1; rd_E = 5; rs2_used_D = 1; rs2_D = 5; sample();
    chk("lu_bubble", 32'(bubble_a), 32'h03);
    chk("lu_flush", 32'(flush_a), 32'h04);
    next_cycle(); set_idle(); sample();
    chk("lu_sc", 32'(sc_a), 32'd1);
    next_cycle(); load_E = 1; rd_E = 0; rs2_used_D = 1; rs2_D = 0; sample();
    chk("x0_bubble", 32'(bubble_a), 32'h0);
    chk("x0_flush", 32'(flush_a), 32'h0);
    next_cycle(); set_idle(); sample();
    chk("x0_sc", 32'(sc_a), 32'd1);

    // Branch beats load-use
    do_reset();
    load_E = 1; rd_E = 7; rs1_used_D = 1; rs1_D = 7; br_taken_E = 1; sample();
    chk("br_flush", 32'(flush_a), 32'h06);
    chk("br_bubble", 32'(bubble_a), 32'h0);
    next_cycle(); set_idle(); sample();
    chk("br_sc", 32'(sc_a), 32'd0);

    // Three stall cycles, ready on the fourth
    do_reset();
    for (int i = 0; i < 3; i++) begin
      miss_M = 1; sample();
      chk("miss3_bubble", 32'(bubble_a), 32'h0f);
      next_cycle(); set_idle();
    end
    miss_M = 1; mem_ready_M = 1; sample();
    chk("miss3_ready_bubble", 32'(bubble_a), 32'h0);
    chk("miss3_ready_flush", 32'(flush_a), 32'h0);
    next_cycle(); set_idle(); sample();
    chk("miss3_sc", 32'(sc_a), 32'd3);
    chk("miss3_to_b", 32'(to_b), 32'd0);

    // Watchdog: miss held 10 cycles, then served
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      miss_M = 1; sample();
      chk("to_b_rise", 32'(to_b), (i >= 6) ? 32'd1 : 32'd0);
      next_cycle(); set_idle();
    end
    miss_M = 1; mem_ready_M = 1; sample();
    chk("to_b_at_ready", 32'(to_b), 32'd1);
    next_cycle(); set_idle(); sample();
    chk("to_b_sticky", 32'(to_b), 32'd1);
    chk("to_a_quiet", 32'(to_a), 32'd0);
    do_reset(); sample();
    chk("to_b_cleared", 32'(to_b), 32'd0);

    // CSR hazard held 20 cycles; dut_b counter saturates
    next_cycle(); set_idle();
    for (int i = 0; i < 20; i++) begin
      csr_read_D = 1; csr_write_en_M = 1; sample();
      chk("csr_bubble", 32'(bubble_a), 32'h03);
      next_cycle(); set_idle();
    end
    sample();
    chk("sat_sc_b", 32'(sc_b), 32'd15);
    chk("sat_sc_a", 32'(sc_a), 32'd20);

    // Randomized run
    miss_act = 0; miss_left = 0;
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      rst            = ($urandom_range(0, 299) == 0);
      rs1_D          = 5'($urandom_range(0, 3));
      rs2_D          = 5'($urandom_range(0, 3));
      rd_E           = 5'($urandom_range(0, 3));
      rs1_used_D     = 1'($urandom_range(0, 1));
      rs2_used_D     = 1'($urandom_range(0, 1));
      csr_read_D     = ($urandom_range(0, 3) == 0);
      jal_D          = ($urandom_range(0, 7) == 0);
      load_E         = ($urandom_range(0, 2) == 0);
      csr_write_en_E = ($urandom_range(0, 5) == 0);
      br_taken_E     = ($urandom_range(0, 5) == 0);
      jalr_E         = ($urandom_range(0, 9) == 0);
      csr_write_en_M = ($urandom_range(0, 5) == 0);
      if (!miss_act && $urandom_range(0, 5) == 0) begin
        miss_act  = 1;
        miss_left = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 75)
                                                : $urandom_range(0, 4);
      end
      if (miss_act) begin
        miss_M = 1;
        if (miss_left == 0) begin
          mem_ready_M = 1; miss_act = 0;
        end else begin
          mem_ready_M = 0; miss_left--;
        end
      end else begin
        miss_M = 0; mem_ready_M = 0;
      end
    end
    next_cycle(); set_idle();
    sample(); sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage RV32I pipeline. Generates per-stage bubble/flush controls for all IF/ID/EX/MEM/WB segment registers, covering:
- load-use hazards
- CSR read-after-write hazards
- taken-branch/jump redirects
- multi-cycle data-memory misses
Holds a small FSM for miss stalls, a miss-timeout watchdog and a saturating stall-cycle performance counter.

Parameters:
MISS_TIMEOUT, 64, MISS-state cycles after which miss_timeout is set (1..2^TO_W-1)
TO_W, 8, width of the internal miss-duration counter
CNT_W, 16, width of stall_cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rs1_D  in  5  rs1 index of the instruction in ID
rs2_D  in  5  rs2 index of the instruction in ID
rs1_used_D  in  1  ID instruction reads rs1
rs2_used_D  in  1  ID instruction reads rs2
csr_read_D  in  1  ID instruction reads a CSR
jal_D  in  1  JAL resolved in ID
rd_E  in  5  destination of the EX instruction
load_E  in  1  EX instruction is a load
csr_write_en_E  in  1  EX instruction writes a CSR
br_taken_E  in  1  branch taken in EX
jalr_E  in  1  JALR in EX
csr_write_en_M  in  1  MEM instruction writes a CSR
miss_M  in  1  data memory miss for the MEM instruction, held until served
mem_ready_M  in  1  miss data valid this cycle
bubble  out  5  bit0=F, bit1=D, bit2=E, bit3=M, bit4=W; hold the segment register
flush  out  5  same bit order; load NOP/zero into the segment register
miss_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  count of cycles with bubble[0]=1

Behaviour:
- Reset is synchronous and active-high on clk.
  - Reset values: state=RUN, miss counter=0, miss_timeout=0, stall_cycles=0.
  - While rst=1: bubble=5'b00000, flush=5'b11111 (pipeline purge).
- bubble and flush are combinational from state and inputs (zero latency). All other outputs are registered.
- Stall condition: stall_m = miss_M & ~mem_ready_M.
- FSM states: RUN, MISS.
  - RUN -> MISS when stall_m.
  - MISS -> RUN when mem_ready_M.
  - MISS holds otherwise.
- Output priority in RUN (first match wins; all bits not listed are 0):
  1. stall_m: bubble=5'b01111, flush=5'b10000.
  2. br_taken_E | jalr_E: flush=5'b00110.
  3. load-use (load_E & rd_E!=0 & ((rs1_used_D & rs1_D==rd_E) | (rs2_used_D & rs2_D==rd_E))): bubble=5'b00011, flush=5'b00100.
  4. CSR hazard (csr_read_D & (csr_write_en_E | csr_write_en_M)): bubble=5'b00011, flush=5'b00100.
  5. jal_D: flush=5'b00010.
- Output in MISS:
  - mem_ready_M=0: bubble=5'b01111, flush=5'b10000; branch/load-use/CSR/jal inputs ignored.
  - mem_ready_M=1: bubble=0, flush=0 (MEM result advances this edge).
- Simultaneous-event rules:
  - Branch beats load-use/CSR/jal: the dependent ID instruction is killed anyway.
  - Miss beats branch: EX is frozen, so the branch re-presents after the miss.
  - miss_M & mem_ready_M in the same cycle in RUN is treated as a hit: no stall, no state change.
- Miss counter:
  - Cleared on entering MISS; increments each MISS cycle, saturating at 2^TO_W-1.
  - When it equals MISS_TIMEOUT-1 while in MISS, miss_timeout is set on that edge.
  - miss_timeout stays set until rst; the FSM keeps waiting regardless.
- stall_cycles increments every cycle with bubble[0]=1 (not during rst) and saturates at all-ones with no wrap.
- Reset mid-miss: next cycle state=RUN, counters cleared; miss_M is re-evaluated in RUN.
- Register x0 never causes a load-use stall.

Test Plan:
- Reset: rst=1 for 2 cycles with miss_M=1 -> flush=5'b11111, bubble=0, stall_cycles=0. After release: bubble=5'b01111, state MISS next cycle.
- Load-use: load_E=1, rd_E=5, rs2_used_D=1, rs2_D=5 -> one cycle of bubble=5'b00011, flush=5'b00100, stall_cycles=1. Same stimulus with rd_E=0 -> no stall.
- Branch vs load-use: br_taken_E=1 together with a load-use match -> flush=5'b00110, bubble=0, stall_cycles unchanged.
- Miss of 3 cycles: miss_M=1, mem_ready_M asserted on the 4th cycle -> bubble=5'b01111 for 3 cycles, then 0 on the ready cycle. stall_cycles=3; state back to RUN.
- Timeout: MISS_TIMEOUT=4, miss held 10 cycles -> miss_timeout rises after the 4th MISS cycle, stays 1 after mem_ready_M, clears only on rst.
- Saturation and CSR hazard: CNT_W=4 with CSR hazard (csr_read_D=1, csr_write_en_M=1) held 20 cycles -> bubble=5'b00011 each cycle, stall_cycles stops at 15.
